// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cellchk_if.sv
// Bundle between the cell-check sequencer and the cell under test.
// master: sequencer side (drives DRV and results, reads START/OBS).
// slave:  bench/cell side (drives START and OBS, reads the rest).
interface gf180mcu_fd_sc_mcu9t5v0__cellchk_if #(
    parameter int N_IN = 3,
    parameter int ERRW = 8
);
    logic            START;
    logic [N_IN-1:0] DRV;
    logic            OBS;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [ERRW-1:0] ERRCNT;
    logic [N_IN-1:0] FAILVEC;
    logic            FAILVLD;

    modport master (
        input  START, OBS,
        output DRV, BUSY, DONE, PASS,
        output ERRCNT, FAILVEC, FAILVLD
    );

    modport slave (
        output START, OBS,
        input  DRV, BUSY, DONE, PASS,
        input  ERRCNT, FAILVEC, FAILVLD
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cellchk.sv
// Exhaustive truth-table checker for a combinational library cell.
// Ports: CLK, RST (async, active high), bus (master modport):
//   START in, OBS in, DRV/BUSY/DONE/PASS/ERRCNT/FAILVEC/FAILVLD out.
// The interface instance must use the same N_IN and ERRW.
module gf180mcu_fd_sc_mcu9t5v0__cellchk #(
    parameter int N_IN   = 3,
    parameter     TRUTH  = 8'h01,
    parameter int SETTLE = 2,
    parameter int ERRW   = 8
) (
    input logic CLK,
    input logic RST,
    gf180mcu_fd_sc_mcu9t5v0__cellchk_if.master bus
);

    localparam int NV = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
    localparam logic [NV-1:0] TT = TRUTH;

    generate
        if (N_IN < 1 || N_IN > 10) begin : g_bad_n
            $error("cellchk: N_IN must be in 1..10");
        end
        if (SETTLE < 1) begin : g_bad_settle
            $error("cellchk: SETTLE must be >= 1");
        end
        if ($bits(TRUTH) != NV) begin : g_bad_truth
            $error("cellchk: TRUTH width must be 2**N_IN");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] drv_q, drv_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [N_IN-1:0] fvec_q, fvec_d;
    logic            fvld_q, fvld_d;
    logic            mism;

    // Expected value is looked up by the vector currently on the cell.
    assign mism = (bus.OBS != TT[drv_q]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            drv_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drv_d   = drv_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        fvld_d  = fvld_q;

        unique case (state_q)
            IDLE, FIN: begin
                if (bus.START) begin
                    state_d = RUN;
                    drv_d   = '0;
                    cnt_d   = RELOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fvec_d  = '0;
                    fvld_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (mism) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fvld_q) begin
                            fvec_d = drv_q;
                            fvld_d = 1'b1;
                        end
                    end
                    if (drv_q != '1) begin
                        drv_d = drv_q + 1'b1;
                        cnt_d = RELOAD;
                    end else begin
                        // fvld_q covers every earlier mismatch.
                        state_d = FIN;
                        drv_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = !(fvld_q || mism);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.DRV     = drv_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.PASS    = pass_q;
    assign bus.ERRCNT  = err_q;
    assign bus.FAILVEC = fvec_q;
    assign bus.FAILVLD = fvld_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__cellchk.sv
// Directed bench for the cell-check sequencer.
// Default NOR3 instance plus a 9-input saturation instance.
module tb_gf180mcu_fd_sc_mcu9t5v0__cellchk;

    logic CLK;
    logic RST;
    int   total;
    int   bad;
    int   mode;
    int   edges;

    gf180mcu_fd_sc_mcu9t5v0__cellchk_if #(.N_IN(3), .ERRW(8)) b0();
    gf180mcu_fd_sc_mcu9t5v0__cellchk_if #(.N_IN(9), .ERRW(8)) b1();

    gf180mcu_fd_sc_mcu9t5v0__cellchk u0 (
        .CLK (CLK),
        .RST (RST),
        .bus (b0.master)
    );

    gf180mcu_fd_sc_mcu9t5v0__cellchk #(
        .N_IN   (9),
        .TRUTH  (512'b0),
        .SETTLE (1),
        .ERRW   (8)
    ) u1 (
        .CLK (CLK),
        .RST (RST),
        .bus (b1.master)
    );

    // mode 0: ideal NOR3, 1: stuck-at-0, 2: stuck-at-1
    assign b0.OBS = (mode == 0) ? ~|b0.DRV : (mode == 2);
    assign b1.OBS = 1'b1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst0(input string tag);
        chk({tag, "_drv"},  32'(b0.DRV), 0);
        chk({tag, "_busy"}, 32'(b0.BUSY), 0);
        chk({tag, "_done"}, 32'(b0.DONE), 0);
        chk({tag, "_pass"}, 32'(b0.PASS), 0);
        chk({tag, "_err"},  32'(b0.ERRCNT), 0);
        chk({tag, "_fvec"}, 32'(b0.FAILVEC), 0);
        chk({tag, "_fvld"}, 32'(b0.FAILVLD), 0);
    endtask

    task automatic results(input string tag, input int pass,
                           input int err, input int fvec,
                           input int fvld);
        chk({tag, "_pass"}, 32'(b0.PASS), 32'(pass));
        chk({tag, "_err"},  32'(b0.ERRCNT), 32'(err));
        chk({tag, "_fvld"}, 32'(b0.FAILVLD), 32'(fvld));
        if (fvld != 0)
            chk({tag, "_fvec"}, 32'(b0.FAILVEC), 32'(fvec));
    endtask

    // Start edge E0 then 16 edges; DONE must rise exactly at E0+16.
    task automatic sweep(input bit repulse, input bit chkdrv);
        @(negedge CLK);
        b0.START = 1'b1;
        @(posedge CLK);
        #1;
        b0.START = 1'b0;
        chk("e0_busy", 32'(b0.BUSY), 1);
        chk("e0_done", 32'(b0.DONE), 0);
        chk("e0_drv",  32'(b0.DRV), 0);
        for (int k = 1; k <= 16; k++) begin
            if (repulse && k == 5) begin
                @(negedge CLK);
                b0.START = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (repulse && k == 5) b0.START = 1'b0;
            if (chkdrv && k < 16)
                chk("drv_step", 32'(b0.DRV), 32'(k / 2));
            if (k == 15) begin
                chk("done_early", 32'(b0.DONE), 0);
                chk("busy_mid", 32'(b0.BUSY), 1);
            end
        end
        chk("done_e16", 32'(b0.DONE), 1);
        chk("busy_end", 32'(b0.BUSY), 0);
        chk("drv_end",  32'(b0.DRV), 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mode     = 0;
        b0.START = 1'b0;
        b1.START = 1'b0;
        RST      = 1'b1;
        #12;
        chk_rst0("rst");
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_done", 32'(b0.DONE), 0);

        mode = 0;
        sweep(1'b0, 1'b1);
        results("nor", 1, 0, 0, 0);

        mode = 1;
        sweep(1'b0, 1'b0);
        results("sa0", 0, 1, 0, 1);

        mode = 2;
        sweep(1'b0, 1'b1);
        results("sa1", 0, 7, 1, 1);
        repeat (3) @(posedge CLK);
        #1;
        chk("sticky_done", 32'(b0.DONE), 1);
        results("sticky", 0, 7, 1, 1);

        mode = 0;
        sweep(1'b1, 1'b1);
        results("repulse", 1, 0, 0, 0);

        // START held high in FIN restarts on the next edge.
        mode = 2;
        sweep(1'b0, 1'b0);
        @(negedge CLK);
        b0.START = 1'b1;
        @(posedge CLK);
        #1;
        chk("b2b_done", 32'(b0.DONE), 0);
        chk("b2b_busy", 32'(b0.BUSY), 1);
        chk("b2b_err",  32'(b0.ERRCNT), 0);
        b0.START = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        chk("b2b_early", 32'(b0.DONE), 0);
        @(posedge CLK);
        #1;
        chk("b2b_fin", 32'(b0.DONE), 1);
        results("b2b", 0, 7, 1, 1);

        // Asynchronous abort in the middle of a clock period.
        mode = 1;
        @(negedge CLK);
        b0.START = 1'b1;
        @(posedge CLK);
        #1;
        b0.START = 1'b0;
        repeat (7) @(posedge CLK);
        #2;
        chk("pre_abort_busy", 32'(b0.BUSY), 1);
        RST = 1'b1;
        #1;
        chk_rst0("abort");
        @(negedge CLK);
        RST = 1'b0;
        mode = 0;
        sweep(1'b0, 1'b0);
        results("fresh", 1, 0, 0, 0);

        // Saturation instance: 512 mismatches into an 8-bit counter.
        @(negedge CLK);
        b1.START = 1'b1;
        @(posedge CLK);
        #1;
        b1.START = 1'b0;
        edges = 0;
        while (b1.DONE !== 1'b1 && edges < 600) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        chk("sat_latency", 32'(edges), 512);
        chk("sat_err",  32'(b1.ERRCNT), 255);
        chk("sat_fvec", 32'(b1.FAILVEC), 0);
        chk("sat_fvld", 32'(b1.FAILVLD), 1);
        chk("sat_pass", 32'(b1.PASS), 0);
        chk("sat_drv",  32'(b1.DRV), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
